pc_redirect_ctrl: RTL
=====================

// Module: pc_redirect_ctrl
// PURPOSE
//  Owns the fetch PC and sequences control-flow redirects from the branch/jump compare stage.
//  Accepts a redirect (jumpSig/newPC) and loads the PC.
//  Squashes younger in-flight instructions for a fixed number of cycles.
//  For link variants (BGEZAL, JAL, JALR, ...), issues a one-shot link-register write.
//  Sits between the branch compare stage, the hazard/stall unit and instruction fetch.
// PARAMETERS
//  WIDTH         32     PC / data width
//  FLUSH_CYCLES  2      younger-instruction squash depth after a redirect (>=1)
//  RESET_PC      32'h0  PC value loaded on reset
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  stall      in   1      hazard unit freeze; PC, counter and state hold
//  jumpSig    in   1      redirect request from branch compare stage
//  newPC      in   WIDTH  redirect target, valid with jumpSig
//  br_pc      in   WIDTH  PC of the branch/jump instruction, valid with jumpSig
//  link_req   in   1      branch is a link variant, valid with jumpSig
//  link_rd    in   5      link destination register (31 for implicit forms)
//  pc         out  WIDTH  current fetch PC
//  fetch_vld  out  1      fetch at pc is valid this cycle
//  flush      out  1      squash younger stages this cycle
//  link_we    out  1      one-cycle link register write strobe
//  link_addr  out  5      link destination register
//  link_data  out  WIDTH  link value
//  busy       out  1      state != RUN
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   - state=RUN, pc=RESET_PC, fetch_vld=0, flush=0, link_we=0
//   - link_addr=0, link_data=0, pending target=0, count=0
//   - fetch_vld rises the first non-stalled cycle after reset.
//   - rst mid-redirect abandons the pending target and the flush.
//  States: RUN, HOLD, FLUSH. All outputs are registered.
//  RUN, jumpSig=0:
//   - stall=0: pc<=pc+4, wrapping mod 2^WIDTH (32'hFFFFFFFC -> 0).
//   - stall=1: pc holds, fetch_vld<=0.
//  RUN, jumpSig=1, stall=0 (accept):
//   - pc<={newPC[WIDTH-1:2],2'b00} (low bits forced 0).
//   - flush<=1, count<=FLUSH_CYCLES-1, -> FLUSH.
//   - If link_req: link_we<=1 for exactly 1 cycle; link_addr<=link_rd; link_data<=br_pc+4 (mod 2^WIDTH).
//  RUN, jumpSig=1, stall=1:
//   - Latch newPC, br_pc, link_req and link_rd into pending regs; pc holds; fetch_vld<=0; -> HOLD.
//  HOLD:
//   - Input jumpSig is ignored.
//   - On first stall=0: perform the accept actions using the pending regs.
//  FLUSH:
//   - flush stays 1 while count>0; count decrements each non-stalled cycle; pc advances +4 each non-stalled cycle.
//   - When count==0 and stall=0: flush<=0, -> RUN.
//   - stall freezes count, pc and flush.
//   - jumpSig is ignored (it originates from squashed instructions).
//  Flush length: flush is high for exactly FLUSH_CYCLES non-stalled cycles following the accept edge.
//  link_we never asserts outside the accept cycle.
//  busy=1 in HOLD and FLUSH.
// CONFIGURATION
//  BRANCH_DELAY_SLOT_EN defined:
//   - The first younger instruction (delay slot) survives.
//   - Flush depth = FLUSH_CYCLES-1; if that is 0, accept goes directly to RUN with flush=0.
//   - link_data = br_pc+8.
//  BRANCH_DELAY_SLOT_EN undefined: behaviour as above (depth FLUSH_CYCLES, link_data = br_pc+4).
// TESTING
//  1. rst=1 for 2 cycles, then free-run 4 cycles -> pc 0,4,8,12; flush=0, link_we=0.
//  2. RUN at pc=0x40; jumpSig=1, newPC=0x100, link_req=0 -> next pc=0x100; flush=1 for 2 cycles; pc 0x104,0x108; no link_we.
//  3. jumpSig=1, link_req=1, link_rd=31, br_pc=0x200 -> link_we pulse 1 cycle, link_addr=31, link_data=0x204 (0x208 with BRANCH_DELAY_SLOT_EN).
//  4. jumpSig=1 with stall=1 for 3 cycles, newPC=0x300 -> HOLD, pc frozen, fetch_vld=0; on release pc=0x300, then 2 flush cycles.
//  5. jumpSig=1 during FLUSH with newPC=0x500 -> ignored; pc continues +4; stall mid-FLUSH extends flush by the stalled cycles.
//  6. pc=0xFFFFFFFC free-run -> pc=0; newPC=0x103 -> pc=0x100; rst mid-FLUSH -> pc=RESET_PC, flush=0 next cycle.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: applies branch/jump redirects, squashes younger stages and issues link writes.
// Optional build macro BRANCH_DELAY_SLOT_EN keeps the delay-slot instruction alive and links br_pc+8.
module pc_redirect_ctrl #(
    parameter int               WIDTH        = 32,
    parameter int               FLUSH_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_PC     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jumpSig,
    input  logic [WIDTH-1:0] newPC,
    input  logic [WIDTH-1:0] br_pc,
    input  logic             link_req,
    input  logic [4:0]       link_rd,
    output logic [WIDTH-1:0] pc,
    output logic             fetch_vld,
    output logic             flush,
    output logic             link_we,
    output logic [4:0]       link_addr,
    output logic [WIDTH-1:0] link_data,
    output logic             busy
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam int               FLUSH_DEPTH = FLUSH_CYCLES - 1;
    localparam logic [WIDTH-1:0] LINK_OFS    = WIDTH'(8);
`else
    localparam int               FLUSH_DEPTH = FLUSH_CYCLES;
    localparam logic [WIDTH-1:0] LINK_OFS    = WIDTH'(4);
`endif

    localparam int               CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'((FLUSH_DEPTH > 0) ? FLUSH_DEPTH - 1 : 0);
    localparam bit               SKIP_FLUSH = (FLUSH_DEPTH == 0);
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

    typedef enum logic [1:0] {
        S_RUN,
        S_HOLD,
        S_FLUSH
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic [WIDTH-1:0] r_pc,        w_pc_nxt;
    logic             r_fetch_vld, w_fetch_vld_nxt;
    logic             r_flush,     w_flush_nxt;
    logic             r_link_we,   w_link_we_nxt;
    logic [4:0]       r_link_addr, w_link_addr_nxt;
    logic [WIDTH-1:0] r_link_data, w_link_data_nxt;
    logic [CNT_W-1:0] r_count,     w_count_nxt;

    // Redirect captured while the pipe was frozen.
    logic [WIDTH-1:0] r_pend_pc,       w_pend_pc_nxt;
    logic [WIDTH-1:0] r_pend_br_pc,    w_pend_br_pc_nxt;
    logic             r_pend_link_req, w_pend_link_req_nxt;
    logic [4:0]       r_pend_link_rd,  w_pend_link_rd_nxt;

    logic             w_accept;
    logic [WIDTH-1:0] w_src_pc;
    logic [WIDTH-1:0] w_src_br_pc;
    logic             w_src_link_req;
    logic [4:0]       w_src_link_rd;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt         = r_state;
        w_pc_nxt            = r_pc;
        w_fetch_vld_nxt     = r_fetch_vld;
        w_flush_nxt         = r_flush;
        w_link_we_nxt       = 1'b0;
        w_link_addr_nxt     = r_link_addr;
        w_link_data_nxt     = r_link_data;
        w_count_nxt         = r_count;
        w_pend_pc_nxt       = r_pend_pc;
        w_pend_br_pc_nxt    = r_pend_br_pc;
        w_pend_link_req_nxt = r_pend_link_req;
        w_pend_link_rd_nxt  = r_pend_link_rd;
        w_accept            = 1'b0;
        w_src_pc            = newPC;
        w_src_br_pc         = br_pc;
        w_src_link_req      = link_req;
        w_src_link_rd       = link_rd;

        unique case (r_state)
            S_RUN: begin
                if (stall) begin
                    w_fetch_vld_nxt = 1'b0;
                    if (jumpSig) begin
                        w_pend_pc_nxt       = newPC;
                        w_pend_br_pc_nxt    = br_pc;
                        w_pend_link_req_nxt = link_req;
                        w_pend_link_rd_nxt  = link_rd;
                        w_state_nxt         = S_HOLD;
                    end
                end else if (jumpSig) begin
                    w_accept = 1'b1;
                end else begin
                    w_pc_nxt        = r_pc + PC_STEP;
                    w_fetch_vld_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                w_src_pc       = r_pend_pc;
                w_src_br_pc    = r_pend_br_pc;
                w_src_link_req = r_pend_link_req;
                w_src_link_rd  = r_pend_link_rd;
                if (stall) w_fetch_vld_nxt = 1'b0;
                else       w_accept        = 1'b1;
            end
            S_FLUSH: begin
                // jumpSig here comes from instructions being squashed, so it is never looked at.
                if (stall) begin
                    w_fetch_vld_nxt = 1'b0;
                end else begin
                    w_pc_nxt        = r_pc + PC_STEP;
                    w_fetch_vld_nxt = 1'b1;
                    if (r_count == '0) begin
                        w_flush_nxt = 1'b0;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_count_nxt = r_count - 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_RUN;
        endcase

        if (w_accept) begin
            w_pc_nxt        = {w_src_pc[WIDTH-1:2], 2'b00};
            w_fetch_vld_nxt = 1'b1;
            if (SKIP_FLUSH) begin
                w_flush_nxt = 1'b0;
                w_state_nxt = S_RUN;
            end else begin
                w_flush_nxt = 1'b1;
                w_count_nxt = CNT_LOAD;
                w_state_nxt = S_FLUSH;
            end
            if (w_src_link_req) begin
                w_link_we_nxt   = 1'b1;
                w_link_addr_nxt = w_src_link_rd;
                w_link_data_nxt = w_src_br_pc + LINK_OFS;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and sampled at the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_RUN;
            r_pc            <= RESET_PC;
            r_fetch_vld     <= 1'b0;
            r_flush         <= 1'b0;
            r_link_we       <= 1'b0;
            r_link_addr     <= '0;
            r_link_data     <= '0;
            r_count         <= '0;
            r_pend_pc       <= '0;
            r_pend_br_pc    <= '0;
            r_pend_link_req <= 1'b0;
            r_pend_link_rd  <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_fetch_vld     <= w_fetch_vld_nxt;
            r_flush         <= w_flush_nxt;
            r_link_we       <= w_link_we_nxt;
            r_link_addr     <= w_link_addr_nxt;
            r_link_data     <= w_link_data_nxt;
            r_count         <= w_count_nxt;
            r_pend_pc       <= w_pend_pc_nxt;
            r_pend_br_pc    <= w_pend_br_pc_nxt;
            r_pend_link_req <= w_pend_link_req_nxt;
            r_pend_link_rd  <= w_pend_link_rd_nxt;
        end
    end

    assign pc        = r_pc;
    assign fetch_vld = r_fetch_vld;
    assign flush     = r_flush;
    assign link_we   = r_link_we;
    assign link_addr = r_link_addr;
    assign link_data = r_link_data;
    assign busy      = (r_state != S_RUN);

endmodule
